// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle for bin2bcd_seq; the neg flag exists only
// when the SIGNED_EN macro is defined.
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
`ifdef SIGNED_EN
    logic                  neg;

    modport master (output start, output bin,
                    input busy, input done, input bcd, input ovf, input neg);
    modport slave  (input start, input bin,
                    output busy, output done, output bcd, output ovf, output neg);
`else
    modport master (output start, output bin,
                    input busy, input done, input bcd, input ovf);
    modport slave  (input start, input bin,
                    output busy, output done, output bcd, output ovf);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define SIGNED_EN for two's complement input with a registered neg flag.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input logic          clk,
    input logic          rst,
    bin2bcd_seq_if.slave bus
);
    localparam int unsigned SCR_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t             state;
    logic [BIN_W-1:0]   shift_reg;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   corr;
    logic               sticky;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   operand;
    logic               busy_r;
    logic               done_r;
    logic               ovf_r;
    logic [SCR_W-1:0]   bcd_r;
`ifdef SIGNED_EN
    logic               neg_pend;
    logic               neg_r;

    // Magnitude in BIN_W unsigned bits, so the most negative value maps correctly.
    assign operand = bus.bin[BIN_W-1] ? (~bus.bin + BIN_W'(1)) : bus.bin;
    assign bus.neg = neg_r;
`else
    assign operand = bus.bin;
`endif

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.bcd  = bcd_r;
    assign bus.ovf  = ovf_r;

    // Digit-local add-3 on the pre-step scratch value.
    always_comb begin
        corr = scratch;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch[4*i +: 4] > 4'd4) begin
                corr[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            sticky    <= 1'b0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
            bcd_r     <= '0;
`ifdef SIGNED_EN
            neg_pend  <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg <= operand;
                        scratch   <= '0;
                        sticky    <= 1'b0;
                        cnt       <= CNT_W'(BIN_W);
                        busy_r    <= 1'b1;
                        state     <= SHIFT;
`ifdef SIGNED_EN
                        neg_pend  <= bus.bin[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    // {carry, scratch, shift_reg} shifted left as one vector.
                    scratch   <= {corr[SCR_W-2:0], shift_reg[BIN_W-1]};
                    shift_reg <= shift_reg << 1;
                    if (corr[SCR_W-1]) begin
                        sticky <= 1'b1;
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_r  <= scratch;
                    ovf_r  <= sticky;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
`ifdef SIGNED_EN
                    neg_r  <= neg_pend;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 8b/3-digit, 8b/2-digit and 16b/5-digit instances.
module tb_bin2bcd_seq;
    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) b8 ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) b2 ();
    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) b16 ();

    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) u8  (.clk(clk), .rst(rst), .bus(b8.slave));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) u2  (.clk(clk), .rst(rst), .bus(b2.slave));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Call at a negedge; returns at the negedge where done is seen (or after timeout).
    task automatic run8(input logic [7:0] v, output logic [11:0] r, output logic o,
                        output int lat, output int bcy);
        b8.bin   = v;
        b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        lat = -1;
        bcy = 0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (b8.busy) bcy++;
            if (b8.done) lat = n;
        end
        r = b8.bcd;
        o = b8.ovf;
    endtask

    task automatic run2(input logic [7:0] v, output logic [7:0] r, output logic o,
                        output int lat);
        b2.bin   = v;
        b2.start = 1'b1;
        @(posedge clk);
        #1;
        b2.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (b2.done) lat = n;
        end
        r = b2.bcd;
        o = b2.ovf;
    endtask

    task automatic run16(input logic [15:0] v, output logic [19:0] r, output logic o,
                         output int lat);
        b16.bin   = v;
        b16.start = 1'b1;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge clk);
            if (b16.done) lat = n;
        end
        r = b16.bcd;
        o = b16.ovf;
    endtask

    task automatic test_reset();
        logic [11:0] r;
        logic        o;
        int          lat;
        int          bcy;
        rst = 1'b1;
        b8.start = 1'b0;  b8.bin = '0;
        b2.start = 1'b0;  b2.bin = '0;
        b16.start = 1'b0; b16.bin = '0;
        repeat (2) @(negedge clk);
        nvec++;
        if (b8.busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", b8.busy); end
        nvec++;
        if (b8.done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", b8.done); end
        nvec++;
        if (b8.bcd !== 12'h000) begin nerr++; $display("FAIL rst_bcd got %h want 000", b8.bcd); end
        nvec++;
        if (b8.ovf !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b want 0", b8.ovf); end
`ifdef SIGNED_EN
        nvec++;
        if (b8.neg !== 1'b0) begin nerr++; $display("FAIL rst_neg got %b want 0", b8.neg); end
`endif
        rst = 1'b0;
        @(negedge clk);
        run8(8'd0, r, o, lat, bcy);
        nvec++;
        if (lat !== 10) begin nerr++; $display("FAIL zero_latency got %0d want 10", lat); end
        nvec++;
        if (bcy !== 9) begin nerr++; $display("FAIL zero_busy_cycles got %0d want 9", bcy); end
        nvec++;
        if (r !== 12'h000) begin nerr++; $display("FAIL zero_bcd got %h want 000", r); end
        nvec++;
        if (o !== 1'b0) begin nerr++; $display("FAIL zero_ovf got %b want 0", o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals [3] = '{8'd255, 8'd99, 8'd128};
        logic [11:0] exps [3] = '{12'h255, 12'h099, 12'h128};
        logic [11:0] r;
        logic        o;
        int          lat;
        int          bcy;
        for (int i = 0; i < 3; i++) begin
            run8(vals[i], r, o, lat, bcy);
            nvec++;
            if (r !== exps[i]) begin
                nerr++; $display("FAIL b2b_bcd[%0d] got %h want %h", i, r, exps[i]);
            end
            nvec++;
            if (o !== 1'b0) begin nerr++; $display("FAIL b2b_ovf[%0d] got %b want 0", i, o); end
            nvec++;
            if (lat !== 10) begin
                nerr++; $display("FAIL b2b_latency[%0d] got %0d want 10", i, lat);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dn = 0;
        @(negedge clk);
        b8.bin   = 8'd200;
        b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        b8.bin   = 8'd7;
        // Start pulses land on a SHIFT edge (n=3) and on the FINISH edge (n=9).
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            b8.start = (n == 3 || n == 9);
            if (b8.done) dn++;
        end
        b8.start = 1'b0;
        nvec++;
        if (dn !== 1) begin nerr++; $display("FAIL ignore_done_count got %0d want 1", dn); end
        nvec++;
        if (b8.bcd !== 12'h200) begin
            nerr++; $display("FAIL ignore_bcd got %h want 200", b8.bcd);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] r;
        logic        o;
        int          lat;
        int          bcy;
        int          dn = 0;
        @(negedge clk);
        b8.bin   = 8'd173;
        b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (b8.busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got %b want 0", b8.busy); end
        nvec++;
        if (b8.done !== 1'b0) begin nerr++; $display("FAIL midrst_done got %b want 0", b8.done); end
        nvec++;
        if (b8.bcd !== 12'h000) begin
            nerr++; $display("FAIL midrst_bcd got %h want 000", b8.bcd);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (b8.done) dn++;
        end
        nvec++;
        if (dn !== 0) begin nerr++; $display("FAIL midrst_no_done got %0d want 0", dn); end
        run8(8'd42, r, o, lat, bcy);
        nvec++;
        if (r !== 12'h042) begin nerr++; $display("FAIL midrst_restart_bcd got %h want 042", r); end
    endtask

    task automatic test_overflow();
        logic [7:0] r;
        logic       o;
        int         lat;
        @(negedge clk);
        run2(8'd255, r, o, lat);
        nvec++;
        if (r !== 8'h55) begin nerr++; $display("FAIL ovf255_bcd got %h want 55", r); end
        nvec++;
        if (o !== 1'b1) begin nerr++; $display("FAIL ovf255_ovf got %b want 1", o); end
        run2(8'd37, r, o, lat);
        nvec++;
        if (r !== 8'h37) begin nerr++; $display("FAIL ovf37_bcd got %h want 37", r); end
        nvec++;
        if (o !== 1'b0) begin nerr++; $display("FAIL ovf37_ovf got %b want 0", o); end
    endtask

    task automatic test_wide();
        logic [19:0] r;
        logic        o;
        int          lat;
        @(negedge clk);
        run16(16'd65535, r, o, lat);
        nvec++;
        if (r !== 20'h65535) begin nerr++; $display("FAIL wide_bcd got %h want 65535", r); end
        nvec++;
        if (lat !== 18) begin nerr++; $display("FAIL wide_latency got %0d want 18", lat); end
        nvec++;
        if (o !== 1'b0) begin nerr++; $display("FAIL wide_ovf got %b want 0", o); end
    endtask

`ifdef SIGNED_EN
    task automatic test_signed();
        logic [7:0]  vals [3] = '{8'h80, 8'hF6, 8'h05};
        logic [11:0] exps [3] = '{12'h128, 12'h010, 12'h005};
        logic        negs [3] = '{1'b1, 1'b1, 1'b0};
        logic [11:0] r;
        logic        o;
        int          lat;
        int          bcy;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            run8(vals[i], r, o, lat, bcy);
            nvec++;
            if (r !== exps[i]) begin
                nerr++; $display("FAIL signed_bcd[%0d] got %h want %h", i, r, exps[i]);
            end
            nvec++;
            if (b8.neg !== negs[i]) begin
                nerr++; $display("FAIL signed_neg[%0d] got %b want %b", i, b8.neg, negs[i]);
            end
            nvec++;
            if (lat !== 10) begin
                nerr++; $display("FAIL signed_latency[%0d] got %0d want 10", i, lat);
            end
        end
    endtask
`endif

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
`ifdef SIGNED_EN
        test_signed();
`else
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_overflow();
        test_wide();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
